// File: rtl/i2s_frame_rx.sv
// I2S receiver: oversamples BCK/LRCK/DATA in the clk domain and emits one {left,right} frame per LRCK period.
// Optional I2S_LOCK_DETECT_EN: start is withheld until LOCK_FRAMES consecutive well-formed frames are seen.
module i2s_frame_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int BCK_TIMEOUT = 255,
    parameter int LOCK_FRAMES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i2s_bck,
    input  logic        i2s_lrck,
    input  logic        i2s_data,
    output logic [63:0] data,
    output logic        start,
    output logic [5:0]  bits_per_ch,
    output logic        frame_err,
    output logic        locked
);
    localparam int I2S_BITS = 32;
    localparam int TW       = $clog2(BCK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SYNC, LEFT, RIGHT} state_t;

    state_t                 state, nxt;
    logic [SYNC_STAGES-1:0] bck_sync, lrck_sync, data_sync;
    logic                   bck_hist, bck_s, lrck_s, data_s, bck_rise;
    logic                   lr_prev, chg, timeout;
    logic                   in_slot, shift_en, close_l, close_r, to_err;
    logic [TW-1:0]          to_cnt;
    logic [I2S_BITS-1:0]    sh, slot_word, left_word, right_word;
    logic [5:0]             cnt, cnt_inc, right_bits;
    logic                   emit_pend, start_ok;

    // input synchronisers plus one history flop on BCK for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bck_sync  <= '0;
            lrck_sync <= '0;
            data_sync <= '0;
            bck_hist  <= 1'b0;
        end else begin
            bck_sync  <= {bck_sync[SYNC_STAGES-2:0], i2s_bck};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
            data_sync <= {data_sync[SYNC_STAGES-2:0], i2s_data};
            bck_hist  <= bck_s;
        end
    end

    assign bck_s    = bck_sync[SYNC_STAGES-1];
    assign lrck_s   = lrck_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign bck_rise = bck_s & ~bck_hist;
    assign chg      = lrck_s ^ lr_prev;
    assign timeout  = !bck_rise && (to_cnt == TW'(BCK_TIMEOUT - 1));

    // current slot word with this bit placed MSB-first; bits past 32 are dropped
    always_comb begin
        slot_word = sh;
        if (!cnt[5])
            slot_word[5'd31 - cnt[4:0]] = data_s;
        cnt_inc = (cnt == 6'd63) ? cnt : cnt + 6'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (bck_rise) begin
            case (state)
                IDLE:    nxt = SYNC;
                SYNC:    if (lr_prev && !lrck_s) nxt = LEFT;
                LEFT:    if (chg) nxt = RIGHT;
                RIGHT:   if (chg) nxt = LEFT;
                default: nxt = IDLE;
            endcase
        end else if (timeout) begin
            nxt = IDLE;
        end
    end

    always_comb begin
        in_slot  = (state == LEFT) || (state == RIGHT);
        shift_en = bck_rise && in_slot;
        close_l  = shift_en && chg && (state == LEFT);
        close_r  = shift_en && chg && (state == RIGHT);
        to_err   = timeout && in_slot;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lr_prev    <= 1'b0;
            to_cnt     <= '0;
            sh         <= '0;
            cnt        <= '0;
            left_word  <= '0;
            right_word <= '0;
            right_bits <= '0;
            emit_pend  <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (bck_rise)
                lr_prev <= lrck_s;
            if (bck_rise || timeout)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TW'(1);
            // the bit on an LRCK change is the last bit of the closing slot
            if (shift_en) begin
                if (chg) begin
                    sh  <= '0;
                    cnt <= '0;
                end else begin
                    sh  <= slot_word;
                    cnt <= cnt_inc;
                end
            end else if (!in_slot) begin
                sh  <= '0;
                cnt <= '0;
            end
            if (close_l)
                left_word <= slot_word;
            if (close_r) begin
                right_word <= slot_word;
                right_bits <= cnt_inc;
            end
            emit_pend <= close_r;
            frame_err <= ((close_l || close_r) && cnt[5]) || to_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data        <= '0;
            start       <= 1'b0;
            bits_per_ch <= '0;
        end else begin
            start <= emit_pend && start_ok;
            if (emit_pend) begin
                data        <= {left_word, right_word};
                bits_per_ch <= right_bits;
            end
        end
    end

`ifdef I2S_LOCK_DETECT_EN
    localparam int GW = $clog2(LOCK_FRAMES + 1);

    logic [5:0]  left_bits;
    logic        left_ovf, frame_good;
    logic [GW-1:0] good_cnt;
    logic [GW:0]   good_inc;

    assign good_inc = {1'b0, good_cnt} + (GW+1)'(1);
    assign start_ok = frame_good && (good_inc >= (GW+1)'(LOCK_FRAMES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_bits  <= '0;
            left_ovf   <= 1'b0;
            frame_good <= 1'b0;
            good_cnt   <= '0;
            locked     <= 1'b0;
        end else begin
            if (close_l) begin
                left_bits <= cnt_inc;
                left_ovf  <= cnt[5];
            end
            if (close_r)
                frame_good <= (cnt_inc == left_bits) && !cnt[5] && !left_ovf;
            // good_cnt parks at LOCK_FRAMES-1 once locked
            if (timeout) begin
                good_cnt <= '0;
                locked   <= 1'b0;
            end else if (emit_pend) begin
                if (frame_good) begin
                    if (!start_ok)
                        good_cnt <= good_inc[GW-1:0];
                    locked <= start_ok;
                end else begin
                    good_cnt <= '0;
                    locked   <= 1'b0;
                end
            end
        end
    end
`else
    assign start_ok = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            locked <= 1'b0;
        else if (timeout)
            locked <= 1'b0;
        else if (emit_pend)
            locked <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_i2s_frame_rx.sv
// Bench for i2s_frame_rx: random I2S streams against a slot-level model of the expected frames.
module tb_i2s_frame_rx;
    logic        clk = 1'b0, reset = 1'b1;
    logic        i2s_bck = 1'b0, i2s_lrck = 1'b0, i2s_data = 1'b0;
    logic [63:0] data;
    logic        start, frame_err, locked;
    logic [5:0]  bits_per_ch;

    int total = 0, bad = 0;
    int err_cnt = 0, good_run = 0;
    logic exp_lock = 1'b0, prev_bit = 1'b0;
    logic [63:0] obs_data[$], exp_data[$];
    logic [5:0]  obs_bits[$], exp_bits[$];

    always #5 clk = ~clk;

    i2s_frame_rx dut (
        .clk(clk), .reset(reset), .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck), .i2s_data(i2s_data),
        .data(data), .start(start), .bits_per_ch(bits_per_ch), .frame_err(frame_err), .locked(locked)
    );

    always @(negedge clk) begin
        if (start) begin
            obs_data.push_back(data);
            obs_bits.push_back(bits_per_ch);
        end
        if (frame_err) err_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one BCK period; data lags LRCK by one bit as in I2S
    task automatic send_bit(input logic lr, input logic b, input int half);
        i2s_lrck = lr;
        i2s_data = prev_bit;
        i2s_bck  = 1'b0;
        clks(half);
        i2s_bck  = 1'b1;
        clks(half);
        prev_bit = b;
    endtask

    task automatic send_bits(input logic lr, input logic [63:0] w, input int hi, input int lo, input int half);
        for (int i = hi; i >= lo; i--) send_bit(lr, w[i], half);
    endtask

    function automatic logic [63:0] rnd(input int n);
        logic [63:0] t;
        t = {$urandom, $urandom};
        if (n < 64) t = t & ((64'd1 << n) - 64'd1);
        return t;
    endfunction

    function automatic logic [31:0] align(input logic [63:0] v, input int n);
        logic [63:0] t;
        if (n <= 32) t = v << (32 - n);
        else         t = v >> (n - 32);
        return t[31:0];
    endfunction

    task automatic model_frame(input logic [63:0] l, input logic [63:0] r, input int n);
        logic push;
`ifdef I2S_LOCK_DETECT_EN
        good_run = (n <= 32) ? good_run + 1 : 0;
        push     = (good_run >= 4);
        exp_lock = push;
`else
        push     = 1'b1;
        exp_lock = 1'b1;
`endif
        if (push) begin
            exp_data.push_back({align(l, n), align(r, n)});
            exp_bits.push_back((n > 63) ? 6'd63 : 6'(n));
        end
    endtask

    task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int n, input int half);
        send_bits(1'b0, l, n - 1, 0, half);
        send_bits(1'b1, r, n - 1, 0, half);
        model_frame(l, r, n);
    endtask

    task automatic clear_obs();
        obs_data.delete(); obs_bits.delete(); exp_data.delete(); exp_bits.delete();
        err_cnt = 0; good_run = 0; exp_lock = 1'b0;
    endtask

    task automatic restart();
        clks(300);
        clear_obs();
    endtask

    // first bit of the next left slot closes the last right slot
    task automatic trail(input int half);
        send_bit(1'b0, 1'($urandom), half);
        clks(8);
    endtask

    task automatic test_reset();
        clks(3);
        total++; if (data !== 64'd0)      begin bad++; $display("FAIL reset data got %h want 0", data); end
        total++; if (start !== 1'b0)      begin bad++; $display("FAIL reset start got %b want 0", start); end
        total++; if (frame_err !== 1'b0)  begin bad++; $display("FAIL reset frame_err got %b want 0", frame_err); end
        total++; if (bits_per_ch !== 6'd0) begin bad++; $display("FAIL reset bits_per_ch got %0d want 0", bits_per_ch); end
        total++; if (locked !== 1'b0)     begin bad++; $display("FAIL reset locked got %b want 0", locked); end
        reset = 1'b0;
        clks(2);
    endtask

    task automatic test_basic32();
        restart();
        repeat (3) send_bit(1'b1, 1'($urandom), 4);
        send_frame(64'h12345678, 64'h9ABCDEF0, 32, 4);
        repeat (3) send_frame(rnd(32), rnd(32), 32, 4);
        trail(4);
        total++; if (obs_data.size() !== exp_data.size())
            begin bad++; $display("FAIL basic32 frames got %0d want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            total++; if (obs_data[i] !== exp_data[i]) begin bad++; $display("FAIL basic32 data[%0d] got %h want %h", i, obs_data[i], exp_data[i]); end
            total++; if (obs_bits[i] !== exp_bits[i]) begin bad++; $display("FAIL basic32 bits[%0d] got %0d want %0d", i, obs_bits[i], exp_bits[i]); end
        end
`ifndef I2S_LOCK_DETECT_EN
        if (obs_data.size() > 0) begin
            total++; if (obs_data[0] !== 64'h123456789ABCDEF0) begin bad++; $display("FAIL basic32 first got %h want 123456789abcdef0", obs_data[0]); end
        end
`endif
        total++; if (err_cnt !== 0)       begin bad++; $display("FAIL basic32 frame_err got %0d want 0", err_cnt); end
        total++; if (locked !== exp_lock) begin bad++; $display("FAIL basic32 locked got %b want %b", locked, exp_lock); end
    endtask

    task automatic test_16bit();
        int n;
        restart();
        send_bit(1'b1, 1'b0, 3);
        send_frame(64'hABCD, 64'h1234, 16, 3);
        repeat (5) begin
            n = ($urandom_range(0, 2) == 0) ? 16 : (($urandom_range(0, 1) == 0) ? 24 : 32);
            send_frame(rnd(n), rnd(n), n, 3);
        end
        trail(3);
        total++; if (obs_data.size() !== exp_data.size())
            begin bad++; $display("FAIL w16 frames got %0d want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            total++; if (obs_data[i] !== exp_data[i]) begin bad++; $display("FAIL w16 data[%0d] got %h want %h", i, obs_data[i], exp_data[i]); end
            total++; if (obs_bits[i] !== exp_bits[i]) begin bad++; $display("FAIL w16 bits[%0d] got %0d want %0d", i, obs_bits[i], exp_bits[i]); end
        end
`ifndef I2S_LOCK_DETECT_EN
        if (obs_data.size() > 0) begin
            total++; if (obs_data[0] !== 64'hABCD000012340000) begin bad++; $display("FAIL w16 first got %h want abcd000012340000", obs_data[0]); end
            total++; if (obs_bits[0] !== 6'd16) begin bad++; $display("FAIL w16 first bits got %0d want 16", obs_bits[0]); end
        end
`endif
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL w16 frame_err got %0d want 0", err_cnt); end
    endtask

    // stream joins mid-slot, and one frame has a sub-timeout BCK pause
    task automatic test_mid_right();
        int half;
        logic [63:0] l, r;
        restart();
        half = $urandom_range(2, 4);
        repeat ($urandom_range(1, 10)) send_bit(1'b0, 1'($urandom), half);
        repeat ($urandom_range(1, 10)) send_bit(1'b1, 1'($urandom), half);
        repeat (2) send_frame(rnd(32), rnd(32), 32, half);
        l = rnd(32);
        r = rnd(32);
        send_bits(1'b0, l, 31, 0, half);
        send_bits(1'b1, r, 31, 16, half);
        clks(200);
        send_bits(1'b1, r, 15, 0, half);
        model_frame(l, r, 32);
        repeat (3) send_frame(rnd(32), rnd(32), 32, half);
        trail(half);
        total++; if (obs_data.size() !== exp_data.size())
            begin bad++; $display("FAIL midright frames got %0d want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            total++; if (obs_data[i] !== exp_data[i]) begin bad++; $display("FAIL midright data[%0d] got %h want %h", i, obs_data[i], exp_data[i]); end
        end
        total++; if (err_cnt !== 0) begin bad++; $display("FAIL midright frame_err got %0d want 0", err_cnt); end
    endtask

    task automatic test_overflow();
        restart();
        repeat (2) send_bit(1'b1, 1'($urandom), 2);
        repeat (3) send_frame(rnd(40), rnd(40), 40, 2);
        trail(2);
        total++; if (obs_data.size() !== exp_data.size())
            begin bad++; $display("FAIL ovf frames got %0d want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            total++; if (obs_data[i] !== exp_data[i]) begin bad++; $display("FAIL ovf data[%0d] got %h want %h", i, obs_data[i], exp_data[i]); end
            total++; if (obs_bits[i] !== exp_bits[i]) begin bad++; $display("FAIL ovf bits[%0d] got %0d want %0d", i, obs_bits[i], exp_bits[i]); end
        end
        total++; if (err_cnt !== 6) begin bad++; $display("FAIL ovf frame_err got %0d want 6", err_cnt); end
    endtask

    task automatic test_timeout();
        int e0, n0;
        restart();
        send_bit(1'b1, 1'b1, 4);
        repeat (2) send_frame(rnd(32), rnd(32), 32, 4);
        trail(4);
        repeat (5) send_bit(1'b0, 1'($urandom), 4);
        clks(4);
        e0 = err_cnt;
        n0 = obs_data.size();
        clks(300);
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL timeout frame_err got %0d want 1", err_cnt - e0); end
        total++; if (locked !== 1'b0)    begin bad++; $display("FAIL timeout locked got %b want 0", locked); end
        total++; if (obs_data.size() !== n0) begin bad++; $display("FAIL timeout starts got %0d want %0d", obs_data.size(), n0); end
        clear_obs();
        repeat (2) send_bit(1'b1, 1'($urandom), 4);
        repeat (5) send_frame(rnd(32), rnd(32), 32, 4);
        trail(4);
        total++; if (obs_data.size() !== exp_data.size())
            begin bad++; $display("FAIL resync frames got %0d want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            total++; if (obs_data[i] !== exp_data[i]) begin bad++; $display("FAIL resync data[%0d] got %h want %h", i, obs_data[i], exp_data[i]); end
        end
        total++; if (err_cnt !== 0)       begin bad++; $display("FAIL resync frame_err got %0d want 0", err_cnt); end
        total++; if (locked !== exp_lock) begin bad++; $display("FAIL resync locked got %b want %b", locked, exp_lock); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] l, r;
        restart();
        send_bit(1'b1, 1'b0, 4);
        repeat (5) send_frame(rnd(32), rnd(32), 32, 4);
        l = rnd(32);
        r = rnd(32);
        send_bits(1'b0, l, 31, 22, 4);
        total++; if (obs_data.size() !== exp_data.size())
            begin bad++; $display("FAIL prereset frames got %0d want %0d", obs_data.size(), exp_data.size()); end
        #2 reset = 1'b1;
        #1;
        total++; if (data !== 64'd0)       begin bad++; $display("FAIL rstmid data got %h want 0", data); end
        total++; if (locked !== 1'b0)      begin bad++; $display("FAIL rstmid locked got %b want 0", locked); end
        total++; if (bits_per_ch !== 6'd0) begin bad++; $display("FAIL rstmid bits_per_ch got %0d want 0", bits_per_ch); end
        total++; if (start !== 1'b0)       begin bad++; $display("FAIL rstmid start got %b want 0", start); end
        clks(3);
        reset = 1'b0;
        clear_obs();
        send_bits(1'b0, l, 21, 0, 4);
        send_bits(1'b1, r, 31, 0, 4);
        repeat (5) send_frame(rnd(32), rnd(32), 32, 4);
        trail(4);
        total++; if (obs_data.size() !== exp_data.size())
            begin bad++; $display("FAIL rstmid frames got %0d want %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            total++; if (obs_data[i] !== exp_data[i]) begin bad++; $display("FAIL rstmid data[%0d] got %h want %h", i, obs_data[i], exp_data[i]); end
        end
        total++; if (locked !== exp_lock) begin bad++; $display("FAIL rstmid locked got %b want %b", locked, exp_lock); end
    endtask

    initial begin
        test_reset();
        test_basic32();
        test_16bit();
        test_mid_right();
        test_overflow();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
